wb_regfile_hilo: RTL

//  Writeback-side architectural state: consumes the wb_* bundle out of the MEM/WB pipeline

---
 rtl/wb_regfile_hilo.sv | 76 +++++++
 1 files changed

// File: rtl/wb_regfile_hilo.sv
// Writeback-side architectural state: 32-entry GPR file plus the HI/LO pair.
// Two combinational GPR read ports and HI/LO outputs, all with same-cycle WB bypass.
module wb_regfile_hilo #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Commit: entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) gpr[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wb_wreg && (wb_wd != '0)) gpr[wb_wd] <= wb_wdata;
      if (wb_whilo) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
    end
  end

  // Read port 1: reset, r0 and disabled reads return zero; WB write bypasses storage.
  always_comb begin
    rdata1 = '0;
    if (!rst && (raddr1 != '0) && re1) begin
      if (wb_wreg && (wb_wd == raddr1)) rdata1 = wb_wdata;
      else                              rdata1 = gpr[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && (raddr2 != '0) && re2) begin
      if (wb_wreg && (wb_wd == raddr2)) rdata2 = wb_wdata;
      else                              rdata2 = gpr[raddr2];
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      if (wb_whilo) begin
        hi_o = wb_hi;
        lo_o = wb_lo;
      end else begin
        hi_o = hi_q;
        lo_o = lo_q;
      end
    end
  end

endmodule
